// File: rtl/pc_redirect_ctrl_if.sv
// pc_redirect_ctrl_if: instruction-fetch request handshake between the PC sequencer and instruction memory
interface pc_redirect_ctrl_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ready;
  modport master (output if_req, if_addr, input if_ready);
  modport slave (input if_req, if_addr, output if_ready);
endinterface

// File: rtl/pc_redirect_ctrl.sv
// pc_redirect_ctrl: fetch PC sequencer selecting sequential, branch, exception and ERET next addresses
module pc_redirect_ctrl #(
  parameter logic [31:0] RESET_VECTOR = 32'hbfc00000,
  parameter logic [31:0] EXC_VECTOR   = 32'hbfc00380
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       stall,
  pc_redirect_ctrl_if.master         fetch,
  input  logic                       br_valid,
  input  logic [31:0]                br_target,
  input  logic                       exc_valid,
  input  logic                       eret_valid,
  input  logic [31:0]                epc,
  output logic [31:0]                pc_out,
  output logic                       flush,
  output logic                       dslot_pending
);
  typedef enum logic [1:0] {IDLE, FETCH, DSLOT} state_t;
  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, pend_q, pend_d;
  logic        advance;
  assign fetch.if_req   = state_q != IDLE;
  assign fetch.if_addr  = pc_q;
  assign pc_out         = pc_q;
  assign dslot_pending  = state_q == DSLOT;
  assign advance        = fetch.if_req & fetch.if_ready & ~stall;
  assign flush          = (exc_valid | eret_valid) & ~reset & (state_q != IDLE);
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_VECTOR;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
    end
  end
  // Redirects override any outstanding unaccepted request; a branch that misses
  // its delay-slot fetch parks its target until that slot is accepted.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    if (exc_valid) begin
      pc_d    = EXC_VECTOR;
      state_d = FETCH;
    end else if (eret_valid) begin
      pc_d    = epc;
      state_d = FETCH;
    end else if (state_q == IDLE) begin
      state_d = FETCH;
    end else if (state_q == DSLOT) begin
      pc_d    = advance ? pend_q : pc_q;
      state_d = advance ? FETCH : DSLOT;
    end else if (br_valid) begin
      pc_d    = advance ? br_target : pc_q;
      pend_d  = advance ? pend_q : br_target;
      state_d = advance ? FETCH : DSLOT;
    end else begin
      pc_d    = advance ? pc_q + 32'd4 : pc_q;
    end
  end
endmodule

// File: doc/pc_redirect_ctrl.md
Name: pc_redirect_ctrl

Overview:
Fetch-address sequencer for the MIPS front end. It owns the fetch PC and selects the next value from four sources: sequential (+4), branch target (after the delay slot), exception vector, and ERET return address. It drives the instruction-fetch request handshake and produces the flush pulse for the front-end pipeline registers.

Parameters:
RESET_VECTOR, 32'hbfc00000, fetch PC loaded on reset (boot loader address)
EXC_VECTOR, 32'hbfc00380, general exception entry PC (BEV=1)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
stall  in  1  decode cannot accept an instruction; fetch PC must not advance
if_req  out  1  fetch request valid
if_addr  out  32  fetch address; always equal to pc_out
if_ready  in  1  instruction memory accepts the request this cycle
br_valid  in  1  taken branch/jump resolved in ID; the instruction at current pc_out is its delay slot
br_target  in  32  branch target, valid with br_valid
exc_valid  in  1  exception committed; redirect to EXC_VECTOR
eret_valid  in  1  ERET committed; redirect to epc
epc  in  32  return address, valid with eret_valid
pc_out  out  32  current fetch PC
flush  out  1  one-cycle pulse; kill in-flight IF/ID contents
dslot_pending  out  1  high in DSLOT state (debug/visibility)

Behaviour:
- Clock is clk. Reset is reset: synchronous, active-high.
- Reset values: pc_out=RESET_VECTOR, state=IDLE, pend_tgt=0, flush=0, if_req=0, dslot_pending=0. Reset has priority over every other input, including mid-DSLOT and a simultaneous exc_valid.
- advance = if_req & if_ready & ~stall. The fetch of pc_out completes in the cycle advance is high.
- States: IDLE, FETCH, DSLOT.
  - IDLE: lasts exactly one cycle after reset deasserts; if_req=0; next state is FETCH.
  - FETCH and DSLOT: if_req=1.
- Per-cycle priority, highest first. Every update takes effect at the next clock edge.
  1. exc_valid: pc_out<=EXC_VECTOR; state<=FETCH; pending branch discarded. Applies regardless of stall/if_ready.
  2. eret_valid: pc_out<=epc; state<=FETCH; pending branch discarded. Applies regardless of stall/if_ready.
  3. FETCH with br_valid:
     - If advance: pc_out<=br_target (delay slot fetched this cycle).
     - Otherwise: pend_tgt<=br_target; state<=DSLOT; pc_out holds.
  4. DSLOT: on advance, pc_out<=pend_tgt and state<=FETCH; otherwise hold. br_valid in DSLOT is ignored (branch in delay slot is architecturally undefined).
  5. FETCH, no event: on advance pc_out<=pc_out+4 (wraps modulo 2^32); otherwise hold.
- flush is combinational: flush = (exc_valid | eret_valid) & ~reset & state!=IDLE. It is high only in the redirect cycle.
- if_req is never withdrawn while if_ready is low, except on a redirect cycle. A redirect takes effect even when the outstanding request was not accepted.
- No alignment check: misaligned br_target/epc are passed to if_addr unchanged. AdEL detection belongs to the exception unit.
- Latency: a redirect becomes visible on pc_out/if_addr 1 cycle after its input.

Test Plan:
- Reset held 3 cycles, then released -> pc_out=bfc00000 during reset; if_req=0 for 1 cycle after release, then 1; if_ready=1, stall=0 -> pc_out bfc00004, bfc00008 on successive cycles.
- stall=1 for 2 cycles while if_ready=1 -> pc_out holds at bfc00008; it advances to bfc0000c the cycle after stall drops.
- pc_out=bfc00010, br_valid=1, br_target=bfc00100, advance=1 -> next cycle pc_out=bfc00100; dslot_pending stays 0.
- pc_out=bfc00010, br_valid=1, br_target=bfc00200, if_ready=0 for 2 cycles -> state DSLOT with pc_out=bfc00010; when if_ready=1, next cycle pc_out=bfc00200 and state FETCH.
- In DSLOT (pend_tgt=bfc00200), exc_valid=1 with if_ready=0 -> flush=1 that cycle; next pc_out=bfc00380, state FETCH; bfc00200 is never fetched.
- exc_valid=1 and eret_valid=1 (epc=80001234) together -> pc_out=bfc00380. eret_valid alone -> pc_out=80001234, flush pulses for 1 cycle. reset together with exc_valid -> pc_out=bfc00000, flush=0.
